// File: rtl/poly_mau_array.sv
// poly_mau_array
// Multi-lane polynomial modular arithmetic unit. Each beat carries LANES
// independent coefficient sets and runs one of six modular operations
// (CT/GS butterfly, pointwise multiply, multiply-accumulate, add, subtract)
// modulo a runtime q, using Barrett reduction for the products.
//
// Timing: a beat accepted on clock edge t leaves with out_valid high after
// edge t+LAT, where LAT = MUL_STAGES + 2. The register chain is:
//   input register -> MUL_STAGES product registers -> Barrett register -> output register.
// Every mode uses the same path, so results leave in acceptance order.
// The whole pipeline advances together whenever the output slot is free or
// being consumed. Bubbles are kept in place rather than collapsed.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   poly_mode                 operation, sampled with each beat
//   poly_q                    modulus (static while poly_busy)
//   poly_barret_m/k           Barrett constant floor(2^k/q) and shift k
//   in_valid/in_ready         input handshake
//   in_lane_en, in_tag        per-lane enable and sideband tag of the beat
//   poly_mau_a/b/c/w          operands, lane i in bits [i*DW +: DW]
//   out_valid/out_ready       output handshake
//   out_tag                   tag of the result beat
//   poly_mau_o0/o1            results, lane i in bits [i*DW +: DW]
//   poly_busy                 at least one beat is in flight
module poly_mau_array #(
  parameter int LANES      = 2,
  parameter int DW         = 24,
  parameter int MUL_STAGES = 3,
  parameter int TAG_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          poly_mode,
  input  logic [DW-1:0]       poly_q,
  input  logic [DW:0]         poly_barret_m,
  input  logic [5:0]          poly_barret_k,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES-1:0]    in_lane_en,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [LANES*DW-1:0] poly_mau_a,
  input  logic [LANES*DW-1:0] poly_mau_b,
  input  logic [LANES*DW-1:0] poly_mau_c,
  input  logic [LANES*DW-1:0] poly_mau_w,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic [LANES*DW-1:0] poly_mau_o0,
  output logic [LANES*DW-1:0] poly_mau_o1,
  output logic                poly_busy
);

  localparam int PW = 2 * DW;
  localparam int VW = LANES * DW;

  typedef enum logic [2:0] {
    MODE_CT   = 3'd0,
    MODE_GS   = 3'd1,
    MODE_PWM  = 3'd2,
    MODE_MAC  = 3'd3,
    MODE_PADD = 3'd4,
    MODE_PSUB = 3'd5
  } mode_e;

  // Modular add and subtract of operands already in [0, q): one correction suffices.
  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic [DW-1:0] q);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                            input logic [DW-1:0] q);
    logic [DW-1:0] d;
    d = x - y;
    if (x < y) d = d + q;
    return d;
  endfunction

  // Barrett reduction of a double-width product. The true remainder
  // p - t*q lies in [0, 3q). That range fits in DW+1 bits, so it is computed
  // modulo 2^(DW+2) and then brought into [0, q) with two conditional subtractions.
  function automatic logic [DW-1:0] barrett(input logic [PW-1:0] p, input logic [DW-1:0] q,
                                            input logic [DW:0] m, input logic [5:0] k);
    logic [3*DW:0] pm;
    logic [DW+1:0] t;
    logic [DW+1:0] tq;
    logic [DW+1:0] r;
    logic [DW+1:0] qx;
    pm = {{(DW+1){1'b0}}, p} * {{(2*DW){1'b0}}, m};
    t  = (DW+2)'(pm >> k);
    qx = {2'b00, q};
    tq = t * qx;
    r  = p[DW+1:0] - tq;
    if (r >= qx) r = r - qx;
    if (r >= qx) r = r - qx;
    return r[DW-1:0];
  endfunction

  // Multiplier operand selection. GS subtracts before it multiplies by w.
  function automatic logic [DW-1:0] mul_x(input logic [2:0] mode, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] q);
    logic [DW-1:0] x;
    case (mode)
      MODE_CT:            x = b;
      MODE_GS:            x = mod_sub(a, b, q);
      MODE_PWM, MODE_MAC: x = a;
      default:            x = '0;
    endcase
    return x;
  endfunction

  function automatic logic [DW-1:0] mul_y(input logic [2:0] mode, input logic [DW-1:0] b,
                                          input logic [DW-1:0] w);
    logic [DW-1:0] y;
    case (mode)
      MODE_CT, MODE_GS:   y = w;
      MODE_PWM, MODE_MAC: y = b;
      default:            y = '0;
    endcase
    return y;
  endfunction

  // The non-multiplied term of each mode is formed early and carried alongside
  // the product. Add/sub-only modes get their final value here. The reserved
  // modes carry a and b through unreduced.
  function automatic logic [DW-1:0] aux0_of(input logic [2:0] mode, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] c,
                                            input logic [DW-1:0] q);
    logic [DW-1:0] v;
    case (mode)
      MODE_CT:            v = a;
      MODE_GS, MODE_PADD: v = mod_add(a, b, q);
      MODE_PWM:           v = '0;
      MODE_MAC:           v = c;
      MODE_PSUB:          v = mod_sub(a, b, q);
      default:            v = a;
    endcase
    return v;
  endfunction

  function automatic logic [DW-1:0] aux1_of(input logic [2:0] mode, input logic [DW-1:0] b);
    logic [DW-1:0] v;
    case (mode)
      MODE_CT, MODE_GS, MODE_PWM, MODE_MAC, MODE_PADD, MODE_PSUB: v = '0;
      default:                                                    v = b;
    endcase
    return v;
  endfunction

  function automatic logic [DW-1:0] fin0_of(input logic [2:0] mode, input logic [DW-1:0] r,
                                            input logic [DW-1:0] aux0, input logic [DW-1:0] q);
    logic [DW-1:0] v;
    case (mode)
      MODE_CT, MODE_MAC: v = mod_add(aux0, r, q);
      MODE_PWM:          v = r;
      default:           v = aux0;
    endcase
    return v;
  endfunction

  function automatic logic [DW-1:0] fin1_of(input logic [2:0] mode, input logic [DW-1:0] r,
                                            input logic [DW-1:0] aux0, input logic [DW-1:0] aux1,
                                            input logic [DW-1:0] q);
    logic [DW-1:0] v;
    case (mode)
      MODE_CT:                                v = mod_sub(aux0, r, q);
      MODE_GS:                                v = r;
      MODE_PWM, MODE_MAC, MODE_PADD, MODE_PSUB: v = '0;
      default:                                v = aux1;
    endcase
    return v;
  endfunction

  logic                 advance;

  logic                 s0_valid;
  logic [2:0]           s0_mode;
  logic [TAG_W-1:0]     s0_tag;
  logic [LANES-1:0]     s0_en;
  logic [VW-1:0]        s0_a, s0_b, s0_c, s0_w;

  logic [MUL_STAGES-1:0] ms_valid;
  logic [2:0]           ms_mode [MUL_STAGES];
  logic [TAG_W-1:0]     ms_tag  [MUL_STAGES];
  logic [LANES-1:0]     ms_en   [MUL_STAGES];
  logic [LANES*PW-1:0]  ms_p    [MUL_STAGES];
  logic [VW-1:0]        ms_aux0 [MUL_STAGES];
  logic [VW-1:0]        ms_aux1 [MUL_STAGES];

  logic                 rd_valid;
  logic [2:0]           rd_mode;
  logic [TAG_W-1:0]     rd_tag;
  logic [LANES-1:0]     rd_en;
  logic [VW-1:0]        rd_r, rd_aux0, rd_aux1;

  logic [LANES*PW-1:0]  pre_p;
  logic [VW-1:0]        pre_aux0, pre_aux1;
  logic [VW-1:0]        red_r;
  logic [VW-1:0]        fin_o0, fin_o1;

  // One global advance: the whole pipeline moves whenever the output slot
  // is empty or is being taken this cycle. in_ready is independent of in_valid.
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign poly_busy = s0_valid | (|ms_valid) | rd_valid | out_valid;

  // Operand preparation from the input register: pick the multiplier inputs,
  // form the wide product and the add/sub-side terms for each lane.
  always_comb begin
    pre_p    = '0;
    pre_aux0 = '0;
    pre_aux1 = '0;
    for (int i = 0; i < LANES; i++) begin
      pre_p[i*PW +: PW] =
        {{DW{1'b0}}, mul_x(s0_mode, s0_a[i*DW +: DW], s0_b[i*DW +: DW], poly_q)} *
        {{DW{1'b0}}, mul_y(s0_mode, s0_b[i*DW +: DW], s0_w[i*DW +: DW])};
      pre_aux0[i*DW +: DW] = aux0_of(s0_mode, s0_a[i*DW +: DW], s0_b[i*DW +: DW],
                                     s0_c[i*DW +: DW], poly_q);
      pre_aux1[i*DW +: DW] = aux1_of(s0_mode, s0_b[i*DW +: DW]);
    end
  end

  // Barrett reduction of the product that leaves the last product register.
  always_comb begin
    red_r = '0;
    for (int i = 0; i < LANES; i++) begin
      red_r[i*DW +: DW] = barrett(ms_p[MUL_STAGES-1][i*PW +: PW], poly_q,
                                  poly_barret_m, poly_barret_k);
    end
  end

  // Final combine of the reduced product with the carried term. Disabled
  // lanes are forced to zero here so their enable only has to travel with the beat.
  always_comb begin
    fin_o0 = '0;
    fin_o1 = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rd_en[i]) begin
        fin_o0[i*DW +: DW] = fin0_of(rd_mode, rd_r[i*DW +: DW], rd_aux0[i*DW +: DW], poly_q);
        fin_o1[i*DW +: DW] = fin1_of(rd_mode, rd_r[i*DW +: DW], rd_aux0[i*DW +: DW],
                                     rd_aux1[i*DW +: DW], poly_q);
      end
    end
  end

  // Input register: captures the beat presented on the ports. A cycle
  // without in_valid becomes a bubble that travels down the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_mode  <= '0;
      s0_tag   <= '0;
      s0_en    <= '0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_c     <= '0;
      s0_w     <= '0;
    end else if (advance) begin
      s0_valid <= in_valid;
      s0_mode  <= poly_mode;
      s0_tag   <= in_tag;
      s0_en    <= in_lane_en;
      s0_a     <= poly_mau_a;
      s0_b     <= poly_mau_b;
      s0_c     <= poly_mau_c;
      s0_w     <= poly_mau_w;
    end
  end

  // Product registers: the first one captures the raw product. The rest give
  // the wide multiplier room to be retimed across MUL_STAGES levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_valid <= '0;
      for (int j = 0; j < MUL_STAGES; j++) begin
        ms_mode[j] <= '0;
        ms_tag[j]  <= '0;
        ms_en[j]   <= '0;
        ms_p[j]    <= '0;
        ms_aux0[j] <= '0;
        ms_aux1[j] <= '0;
      end
    end else if (advance) begin
      ms_valid[0] <= s0_valid;
      ms_mode[0]  <= s0_mode;
      ms_tag[0]   <= s0_tag;
      ms_en[0]    <= s0_en;
      ms_p[0]     <= pre_p;
      ms_aux0[0]  <= pre_aux0;
      ms_aux1[0]  <= pre_aux1;
      for (int j = 1; j < MUL_STAGES; j++) begin
        ms_valid[j] <= ms_valid[j-1];
        ms_mode[j]  <= ms_mode[j-1];
        ms_tag[j]   <= ms_tag[j-1];
        ms_en[j]    <= ms_en[j-1];
        ms_p[j]     <= ms_p[j-1];
        ms_aux0[j]  <= ms_aux0[j-1];
        ms_aux1[j]  <= ms_aux1[j-1];
      end
    end
  end

  // Barrett register: holds the fully reduced product next to its carried terms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_mode  <= '0;
      rd_tag   <= '0;
      rd_en    <= '0;
      rd_r     <= '0;
      rd_aux0  <= '0;
      rd_aux1  <= '0;
    end else if (advance) begin
      rd_valid <= ms_valid[MUL_STAGES-1];
      rd_mode  <= ms_mode[MUL_STAGES-1];
      rd_tag   <= ms_tag[MUL_STAGES-1];
      rd_en    <= ms_en[MUL_STAGES-1];
      rd_r     <= red_r;
      rd_aux0  <= ms_aux0[MUL_STAGES-1];
      rd_aux1  <= ms_aux1[MUL_STAGES-1];
    end
  end

  // Output register: holds result, tag and valid steady while downstream
  // stalls. Reset clears it at once, so no in-flight beat survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_tag     <= '0;
      poly_mau_o0 <= '0;
      poly_mau_o1 <= '0;
    end else if (advance) begin
      out_valid   <= rd_valid;
      out_tag     <= rd_tag;
      poly_mau_o0 <= fin_o0;
      poly_mau_o1 <= fin_o1;
    end
  end

endmodule

// File: tb/tb_poly_mau_array.sv
// tb_poly_mau_array
// Self-checking bench for poly_mau_array. Accepted beats are run through a
// plain-arithmetic model and queued. Each output handshake is compared
// against the oldest queued result. Directed beats also check the known
// constants, the latency, the stall behaviour, lane enables and mid-stream reset.
module tb_poly_mau_array;

  localparam int LANES      = 2;
  localparam int DW         = 24;
  localparam int MUL_STAGES = 3;
  localparam int TAG_W      = 8;
  localparam int LAT        = MUL_STAGES + 2;
  localparam int VW         = LANES * DW;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       poly_mode;
  logic [DW-1:0]    poly_q;
  logic [DW:0]      poly_barret_m;
  logic [5:0]       poly_barret_k;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_lane_en;
  logic [TAG_W-1:0] in_tag;
  logic [VW-1:0]    poly_mau_a, poly_mau_b, poly_mau_c, poly_mau_w;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [VW-1:0]    poly_mau_o0, poly_mau_o1;
  logic             poly_busy;

  poly_mau_array #(.LANES(LANES), .DW(DW), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .poly_mode(poly_mode), .poly_q(poly_q),
    .poly_barret_m(poly_barret_m), .poly_barret_k(poly_barret_k),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_en(in_lane_en), .in_tag(in_tag),
    .poly_mau_a(poly_mau_a), .poly_mau_b(poly_mau_b), .poly_mau_c(poly_mau_c),
    .poly_mau_w(poly_mau_w), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .poly_mau_o0(poly_mau_o0), .poly_mau_o1(poly_mau_o1),
    .poly_busy(poly_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VW-1:0]    o0;
    logic [VW-1:0]    o1;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  longint           cur_q;
  bit               accepted;
  bit               saw_out;
  int               out_count = 0;
  bit               prev_stall = 1'b0;
  logic [VW-1:0]    held_o0, held_o1, last_o0, last_o1;
  logic [TAG_W-1:0] held_tag;
  logic [TAG_W-1:0] tag_ctr = '0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic longint mmul(input longint x, input longint y);
    return (x * y) % cur_q;
  endfunction

  function automatic longint madd(input longint x, input longint y);
    return (x + y) % cur_q;
  endfunction

  function automatic longint msub(input longint x, input longint y);
    return (x - y + cur_q) % cur_q;
  endfunction

  function automatic exp_t model(input logic [2:0] mode, input logic [LANES-1:0] en,
                                 input logic [TAG_W-1:0] tag, input logic [VW-1:0] a,
                                 input logic [VW-1:0] b, input logic [VW-1:0] c,
                                 input logic [VW-1:0] w);
    exp_t   e;
    longint la, lb, lc, lw, r0, r1;
    e.tag = tag;
    e.o0  = '0;
    e.o1  = '0;
    for (int i = 0; i < LANES; i++) begin
      la = longint'(a[i*DW +: DW]);
      lb = longint'(b[i*DW +: DW]);
      lc = longint'(c[i*DW +: DW]);
      lw = longint'(w[i*DW +: DW]);
      case (mode)
        3'd0: begin r0 = madd(la, mmul(lb, lw)); r1 = msub(la, mmul(lb, lw)); end
        3'd1: begin r0 = madd(la, lb);           r1 = mmul(msub(la, lb), lw); end
        3'd2: begin r0 = mmul(la, lb);           r1 = 0; end
        3'd3: begin r0 = madd(mmul(la, lb), lc); r1 = 0; end
        3'd4: begin r0 = madd(la, lb);           r1 = 0; end
        3'd5: begin r0 = msub(la, lb);           r1 = 0; end
        default: begin r0 = la;                  r1 = lb; end
      endcase
      if (!en[i]) begin
        r0 = 0;
        r1 = 0;
      end
      e.o0[i*DW +: DW] = r0[DW-1:0];
      e.o1[i*DW +: DW] = r1[DW-1:0];
    end
    return e;
  endfunction

  task automatic setModulus(input longint q, input int k);
    longint one;
    one           = 1;
    cur_q         = q;
    poly_q        = DW'(q);
    poly_barret_k = 6'(k);
    poly_barret_m = (DW+1)'((one << k) / q);
  endtask

  // Drives one cycle's inputs at the falling edge, then samples just after
  // it to see which handshakes the next rising edge will complete.
  task automatic applyStimulus(input bit v, input logic [2:0] mode, input logic [LANES-1:0] en,
                               input logic [TAG_W-1:0] tag, input logic [VW-1:0] a,
                               input logic [VW-1:0] b, input logic [VW-1:0] c,
                               input logic [VW-1:0] w, input bit ordy);
    exp_t e;
    @(negedge clk);
    in_valid   = v;
    poly_mode  = mode;
    in_lane_en = en;
    in_tag     = tag;
    poly_mau_a = a;
    poly_mau_b = b;
    poly_mau_c = c;
    poly_mau_w = w;
    out_ready  = ordy;
    #1;
    accepted = v && in_ready;
    saw_out  = out_valid;
    checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
    if (prev_stall) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_tag", out_tag, held_tag);
      checkOutput("hold_o0", poly_mau_o0, held_o0);
      checkOutput("hold_o1", poly_mau_o1, held_o1);
    end
    if (out_valid && out_ready) begin
      out_count++;
      last_o0 = poly_mau_o0;
      last_o1 = poly_mau_o1;
      if (sb.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("out_tag", out_tag, e.tag);
        checkOutput("out_o0", poly_mau_o0, e.o0);
        checkOutput("out_o1", poly_mau_o1, e.o1);
      end
    end
    if (accepted) sb.push_back(model(mode, en, tag, a, b, c, w));
    prev_stall = out_valid && !out_ready;
    held_tag   = out_tag;
    held_o0    = poly_mau_o0;
    held_o1    = poly_mau_o1;
  endtask

  task automatic idle(input bit ordy);
    applyStimulus(1'b0, 3'd0, '0, '0, '0, '0, '0, '0, ordy);
  endtask

  task automatic randOps(output logic [VW-1:0] a, output logic [VW-1:0] b,
                         output logic [VW-1:0] c, output logic [VW-1:0] w);
    for (int i = 0; i < LANES; i++) begin
      a[i*DW +: DW] = DW'($urandom_range(int'(cur_q - 1)));
      b[i*DW +: DW] = DW'($urandom_range(int'(cur_q - 1)));
      c[i*DW +: DW] = DW'($urandom_range(int'(cur_q - 1)));
      w[i*DW +: DW] = DW'($urandom_range(int'(cur_q - 1)));
    end
  endtask

  // One beat on an empty pipe, then wait for it and check the edge count.
  task automatic runSingle(input string name, input logic [2:0] mode, input logic [VW-1:0] a,
                           input logic [VW-1:0] b, input logic [VW-1:0] c,
                           input logic [VW-1:0] w);
    int n;
    applyStimulus(1'b1, mode, '1, tag_ctr, a, b, c, w, 1'b1);
    checkOutput({name, "_accept"}, accepted, 1);
    tag_ctr++;
    n = 0;
    do begin
      idle(1'b1);
      n++;
    end while (!saw_out && n < 20);
    checkOutput({name, "_latency"}, n - 1, LAT);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || poly_busy) && n < 100) begin
      idle(1'b1);
      n++;
    end
    checkOutput("drain_empty", sb.size(), 0);
    checkOutput("drain_idle", poly_busy, 0);
  endtask

  task automatic randomPhase(input int cycles);
    logic [VW-1:0] a, b, c, w;
    for (int i = 0; i < cycles; i++) begin
      randOps(a, b, c, w);
      applyStimulus($urandom_range(9) < 7, 3'($urandom_range(7)), LANES'($urandom_range(3)),
                    tag_ctr, a, b, c, w, $urandom_range(3) != 0);
      if (accepted) tag_ctr++;
    end
    drain();
  endtask

  initial begin
    logic [VW-1:0] a, b, c, w;
    int idx, cyc, base, gaps, n;
    bit first_seen;

    rst        = 1'b1;
    in_valid   = 1'b0;
    poly_mode  = '0;
    in_lane_en = '0;
    in_tag     = '0;
    poly_mau_a = '0;
    poly_mau_b = '0;
    poly_mau_c = '0;
    poly_mau_w = '0;
    out_ready  = 1'b0;
    setModulus(8380417, 46);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", poly_busy, 0);
    checkOutput("reset_o0", poly_mau_o0, 0);
    checkOutput("reset_o1", poly_mau_o1, 0);
    checkOutput("reset_tag", out_tag, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", in_ready, 1);

    $display("[TB] directed Dilithium beats");
    runSingle("ct", 3'd0, {24'd0, 24'd5}, {24'd0, 24'd3}, '0, {24'd0, 24'd2});
    checkOutput("ct_o0", last_o0[DW-1:0], 11);
    checkOutput("ct_o1", last_o1[DW-1:0], 8380416);
    runSingle("pwm", 3'd2, {24'd8380416, 24'd0}, {24'd8380416, 24'd0}, '0, '0);
    checkOutput("pwm_lane1_o0", last_o0[2*DW-1:DW], 1);
    runSingle("padd", 3'd4, {24'd0, 24'd8380416}, {24'd0, 24'd1}, '0, '0);
    checkOutput("padd_o0", last_o0[DW-1:0], 0);
    runSingle("psub", 3'd5, {24'd0, 24'd0}, {24'd0, 24'd1}, '0, '0);
    checkOutput("psub_o0", last_o0[DW-1:0], 8380416);
    runSingle("mac", 3'd3, {24'd0, 24'd2}, {24'd0, 24'd3}, {24'd0, 24'd8380415}, '0);
    checkOutput("mac_o0", last_o0[DW-1:0], 4);
    runSingle("gs", 3'd1, {24'd0, 24'd1}, {24'd0, 24'd2}, '0, {24'd0, 24'd3});
    checkOutput("gs_o0", last_o0[DW-1:0], 3);
    checkOutput("gs_o1", last_o1[DW-1:0], 8380414);

    $display("[TB] directed Kyber beat");
    setModulus(3329, 24);
    checkOutput("kyber_m", poly_barret_m, 5039);
    runSingle("kyber_pwm", 3'd2, {24'd0, 24'd3328}, {24'd0, 24'd3328}, '0, '0);
    checkOutput("kyber_o0", last_o0[DW-1:0], 1);
    checkOutput("kyber_o1", last_o1[DW-1:0], 0);
    setModulus(8380417, 46);

    $display("[TB] 20-beat stream with output stall");
    idx  = 0;
    cyc  = 0;
    base = out_count;
    while ((idx < 20 || sb.size() > 0) && cyc < 200) begin
      randOps(a, b, c, w);
      applyStimulus(idx < 20, 3'($urandom_range(5)), '1, TAG_W'(idx), a, b, c, w,
                    !(cyc >= 4 && cyc <= 13));
      if (accepted) idx++;
      cyc++;
    end
    checkOutput("stream_count", out_count - base, 20);
    checkOutput("stream_left", sb.size(), 0);

    $display("[TB] lane enable 01 mixed modes");
    idx        = 0;
    cyc        = 0;
    base       = out_count;
    gaps       = 0;
    first_seen = 1'b0;
    while (out_count - base < 12 && cyc < 100) begin
      randOps(a, b, c, w);
      applyStimulus(idx < 12, 3'(idx % 8), 2'b01, tag_ctr, a, b, c, w, 1'b1);
      if (accepted) begin
        idx++;
        tag_ctr++;
      end
      if (saw_out) begin
        first_seen = 1'b1;
        checkOutput("lane1_o0_zero", last_o0[2*DW-1:DW], 0);
        checkOutput("lane1_o1_zero", last_o1[2*DW-1:DW], 0);
      end else if (first_seen) begin
        gaps++;
      end
      cyc++;
    end
    checkOutput("lane_en_count", out_count - base, 12);
    checkOutput("lane_en_gaps", gaps, 0);

    $display("[TB] reset with beats in flight");
    for (int i = 0; i < 3; i++) begin
      randOps(a, b, c, w);
      applyStimulus(1'b1, 3'd2, '1, tag_ctr, a, b, c, w, 1'b0);
      tag_ctr++;
    end
    n = 0;
    while (!saw_out && n < 20) begin
      idle(1'b0);
      n++;
    end
    checkOutput("prefill_valid", out_valid, 1);
    checkOutput("prefill_busy", poly_busy, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_busy", poly_busy, 0);
    checkOutput("midrst_o0", poly_mau_o0, 0);
    checkOutput("midrst_o1", poly_mau_o1, 0);
    checkOutput("midrst_tag", out_tag, 0);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (10) begin
      idle(1'b1);
      if (saw_out) n++;
    end
    checkOutput("postrst_no_output", n, 0);
    checkOutput("postrst_busy", poly_busy, 0);
    runSingle("postrst", 3'd4, {24'd0, 24'd7}, {24'd0, 24'd9}, '0, '0);
    checkOutput("postrst_o0", last_o0[DW-1:0], 16);

    $display("[TB] random traffic");
    randomPhase(150);
    setModulus(3329, 24);
    randomPhase(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_mau_array.md
Name: poly_mau_array

Overview:
- Parametrised, multi-lane successor to the single-lane polynomial modular arithmetic unit.
- Processes LANES independent coefficient pairs per beat: CT/GS butterflies, pointwise multiply, multiply-accumulate, add and subtract modulo a runtime q (Kyber or Dilithium).
- Uses a uniform fixed latency across all modes, a valid/ready handshake on both sides, and stall propagation, so it can sit directly between the polynomial RAM read ports and the writeback path.

Parameters:
- LANES, 2, number of parallel arithmetic lanes.
- DW, 24, coefficient width; q must satisfy q < 2^(DW-1).
- MUL_STAGES, 3, register stages inside the modular multiplier (≥1).
- TAG_W, 8, sideband tag width carried alongside each beat.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- poly_mode  in  3  operation, sampled with the input beat.
- poly_q  in  DW  modulus, static while busy.
- poly_barret_m  in  DW+1  Barrett constant, floor(2^k/q).
- poly_barret_k  in  6  Barrett shift k; k ≥ 2*ceil(log2 q).
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_lane_en  in  LANES  per-lane enable.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- poly_mau_a / _b / _c / _w  in  LANES*DW each  lane i occupies bits [i*DW +: DW].
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_tag  out  TAG_W  tag of the result beat.
- poly_mau_o0 / _o1  out  LANES*DW each  results.
- poly_busy  out  1  at least one beat in flight.

Behaviour:
- Modes (r = result mod q, always in [0, q)):
  - 000 CT: o0 = a + b*w, o1 = a − b*w.
  - 001 GS: o0 = a + b, o1 = (a − b)*w.
  - 010 PWM: o0 = a*b, o1 = 0.
  - 011 MAC: o0 = a*b + c, o1 = 0.
  - 100 PADD: o0 = a + b, o1 = 0.
  - 101 PSUB: o0 = a − b, o1 = 0.
  - 110/111 reserved: o0 = a, o1 = b, unreduced.
- Operand range: inputs a, b, c, w < q are required; for inputs ≥ q the result is unspecified, but the pipeline never deadlocks.
- Modular multiply: p = x*y (2*DW bits); t = (p*m) >> k; r = p − t*q; then up to two conditional subtractions of q. The multiply is spread over MUL_STAGES registers.
- Modular add/sub: single conditional correction.
- Latency: LAT = MUL_STAGES + 2 (input register, MUL_STAGES, final add/sub register). All modes use the same latency, so results leave in acceptance order.
- Handshake:
  - A beat is accepted on a clk edge with in_valid & in_ready.
  - Without stalls, a beat accepted at edge t appears with out_valid high after edge t+LAT.
  - out_valid is held with stable data and tag until out_ready.
- Stall:
  - Global advance = ~out_valid | out_ready; in_ready = advance.
  - Every pipeline stage (data, mode, tag, lane_en, valid bit) holds when advance = 0.
  - Bubbles are not collapsed.
  - in_ready must not combinationally depend on in_valid.
- Throughput: one beat per clock when out_ready is held high.
- Lane enable: lanes with in_lane_en[i] = 0 output o0 = o1 = 0 for that beat. Each lane's enable travels with its beat.
- Runtime inputs: poly_mode is sampled per beat. poly_q, poly_barret_m and poly_barret_k must be static while poly_busy = 1.
- poly_busy: OR of all stage valid bits, including the output stage.
- Reset:
  - All stage valid bits, out_valid, poly_busy = 0; poly_mau_o0/o1 = 0; out_tag = 0. in_ready = 1 once rst is low.
  - Assertion mid-stream discards all in-flight beats immediately (asynchronous). No partial beat is emitted after release.
- Simultaneous output handshake and input acceptance: both occur in the same cycle at full rate.

Test Plan:
- CT, Dilithium (q = 8380417, k = 46, m = floor(2^46/q)), lane0 a = 5, b = 3, w = 2 -> after LAT cycles o0 = 11, o1 = 8380416.
- PWM, lane1 a = b = 8380416 -> o0 = 1. Kyber (q = 3329, k = 24, m = 5039), a = b = 3328 -> o0 = 1, o1 = 0.
- PADD 8380416 + 1 -> 0; PSUB 0 − 1 -> 8380416; MAC a = 2, b = 3, c = 8380415 -> o0 = 4; GS a = 1, b = 2, w = 3 -> o0 = 3, o1 = 8380414.
- Stream 20 beats with tags 0..19 while out_ready is low for cycles 4–13 -> all 20 outputs emitted, in tag order, no duplicates; in_ready low exactly while the output is stalled.
- Mixed-mode back-to-back beats with in_lane_en = 2'b01 -> lane1 outputs 0; lane0 correct per mode; out_valid continuous at one beat per clock.
- Assert rst with 3 beats in flight -> out_valid, poly_busy, outputs = 0 immediately; no result appears after release until a new beat is accepted.
